// File: rtl/fpu_fdiv.sv
// IEEE-754 binary32 divider y = x1 / x2: input register, long-divide stage, round/pack stage.
// Define FDIV_SPECIAL_EN to add NaN/Inf/zero-divisor detection.
module fpu_fdiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  output logic [31:0] y
);

  localparam int DATA_W = 32;

  // Restoring division of two 1.f mantissas: returns {sticky, q[25:0]}.
  function automatic logic [26:0] long_div(input logic [23:0] m1, input logic [23:0] m2);
    logic [24:0] rem;
    logic [25:0] q;
    rem = {1'b0, m1};
    q   = '0;
    for (int i = 25; i >= 0; i--) begin
      if (rem >= {1'b0, m2}) begin
        q[i] = 1'b1;
        rem  = rem - {1'b0, m2};
      end
      rem = {rem[23:0], 1'b0};
    end
    return {|rem, q};
  endfunction

  function automatic logic [DATA_W-1:0] saturate(input logic sign, input logic signed [9:0] e,
                                                 input logic [22:0] frac);
    if (e >= 10'sd255)
      return {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      return {sign, 31'd0};
    else
      return {sign, e[7:0], frac};
  endfunction

  function automatic logic [DATA_W-1:0] round_rne(input logic sign, input logic signed [9:0] e,
                                                  input logic [25:0] q, input logic sticky);
    logic [23:0]       mant;
    logic              g;
    logic              s;
    logic [24:0]       mr;
    logic signed [9:0] ef;
    if (q[25]) begin
      mant = q[25:2];
      g    = q[1];
      s    = q[0] | sticky;
      ef   = e;
    end else begin
      mant = q[24:1];
      g    = q[0];
      s    = sticky;
      ef   = e - 10'sd1;
    end
    mr = {1'b0, mant} + {24'd0, g & (s | mant[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      ef = ef + 10'sd1;
    end
    return saturate(sign, ef, mr[22:0]);
  endfunction

  logic              vld_p0, vld_p1, vld_p2;
  logic [31:0]       x1_p0, x2_p0;
  logic              sign_p1, zero_p1, stk_p1;
  logic [25:0]       q_p1;
  logic signed [9:0] exp_p1;
  logic [31:0]       y_p2;
  logic [31:0]       res_p1;
  logic signed [9:0] exp_c;
  logic [26:0]       div_c;

  // Stage 1: mantissa long division and biased exponent
  assign exp_c = $signed({2'b00, x1_p0[30:23]}) - $signed({2'b00, x2_p0[30:23]}) + 10'sd127;
  assign div_c = long_div({1'b1, x1_p0[22:0]}, {1'b1, x2_p0[22:0]});

`ifdef FDIV_SPECIAL_EN
  logic        spc_c, spc_p1;
  logic [31:0] spcy_c, spcy_p1;
  logic        nan1, nan2, inf1, inf2, zero1, zero2, sgn_c;

  always_comb begin
    nan1   = (&x1_p0[30:23]) & (|x1_p0[22:0]);
    nan2   = (&x2_p0[30:23]) & (|x2_p0[22:0]);
    inf1   = (&x1_p0[30:23]) & ~(|x1_p0[22:0]);
    inf2   = (&x2_p0[30:23]) & ~(|x2_p0[22:0]);
    zero1  = ~(|x1_p0[30:23]);
    zero2  = ~(|x2_p0[30:23]);
    sgn_c  = x1_p0[31] ^ x2_p0[31];
    spc_c  = 1'b0;
    spcy_c = '0;
    if (nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2)) begin
      spc_c  = 1'b1;
      spcy_c = 32'h7FC00000;
    end else if (inf1) begin
      spc_c  = 1'b1;
      spcy_c = {sgn_c, 8'hFF, 23'd0};
    end else if (inf2) begin
      spc_c  = 1'b1;
      spcy_c = {sgn_c, 31'd0};
    end else if (zero2) begin
      spc_c  = 1'b1;
      spcy_c = {sgn_c, 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      spc_p1  <= spc_c;
      spcy_p1 <= spcy_c;
    end
  end

  always_comb begin
    res_p1 = zero_p1 ? {sign_p1, 31'd0} : round_rne(sign_p1, exp_p1, q_p1, stk_p1);
    if (spc_p1)
      res_p1 = spcy_p1;
  end
`else
  always_comb begin
    res_p1 = zero_p1 ? {sign_p1, 31'd0} : round_rne(sign_p1, exp_p1, q_p1, stk_p1);
  end
`endif

  always_ff @(posedge clk) begin
    if (in_valid) begin
      x1_p0 <= x1;
      x2_p0 <= x2;
    end
    if (vld_p0) begin
      sign_p1 <= x1_p0[31] ^ x2_p0[31];
      zero_p1 <= ~(|x1_p0[30:23]);
      q_p1    <= div_c[25:0];
      stk_p1  <= div_c[26];
      exp_p1  <= exp_c;
    end
  end

  // Stage 2: normalize, round, pack; y holds across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      y_p2   <= '0;
    end else begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1)
        y_p2 <= res_p1;
    end
  end

  assign out_valid = vld_p2;
  assign y         = y_p2;

endmodule

// File: tb/tb_fpu_fdiv.sv
// Scoreboard bench for fpu_fdiv: driver pushes model results, monitor pops on out_valid.
`timescale 1ns/1ps
module tb_fpu_fdiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        out_valid;
  logic [31:0] y;

  typedef struct {
    logic [31:0] y;
    bit          exact;
    int          iss;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_rst = 1'b0;
  bit   final_chk = 1'b0;

  fpu_fdiv dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .x1       (x1),
    .x2       (x2),
    .out_valid(out_valid),
    .y        (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact quotient by integer division, then round-to-nearest-even to 24 bits.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        sign;
    logic [63:0] m1, m2, num, q, remb, half, mant;
    bit          inexact;
    int          e, sh;
    sign = a[31] ^ b[31];
    if (a[30:23] == 8'd0) return {sign, 31'd0};
    m1 = {40'd0, 1'b1, a[22:0]};
    m2 = {40'd0, 1'b1, b[22:0]};
    num = m1 << 40;
    q = num / m2;
    inexact = (num % m2) != 64'd0;
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e = e - 1;
    end
    mant = q >> sh;
    remb = q & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (remb > half || (remb == half && (inexact || mant[0]))) mant = mant + 64'd1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    if (e <= 0) return {sign, 31'd0};
    return {sign, 8'(e), mant[22:0]};
  endfunction

  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input bit exact);
    exp_t t;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x1 = a;
    x2 = b;
    t.y = ey;
    t.exact = exact;
    t.iss = cyc;
    t.a = a;
    t.b = b;
    sb.push_back(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
  endtask

  function automatic logic [22:0] pick_frac();
    logic [22:0] fc[7] = '{23'h0, 23'h1, 23'h2, 23'h380000, 23'h400000, 23'h5FFFFF, 23'h7FFFFF};
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return fc[r];
    return 23'($urandom);
  endfunction

  // Monitor: compares each DUT output against the oldest expected entry.
  initial begin : monitor
    exp_t   e;
    longint d;
    bit     ok;
    forever begin
      @(negedge clk);
      if (chk_rst) begin
        n_cmp++;
        if (out_valid !== 1'b0 || y !== 32'd0) begin
          n_bad++;
          $display("FAIL reset_state: out_valid=%b y=%h, required out_valid=0 y=00000000", out_valid, y);
        end
      end
      if (out_valid !== 1'b0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_output: out_valid=%b y=%h with nothing outstanding, required out_valid=0", out_valid, y);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (cyc - e.iss != 3) begin
            n_bad++;
            $display("FAIL latency %h/%h: result after %0d edges, required 2 edges after sampling", e.a, e.b, cyc - e.iss - 1);
          end
          d = longint'({32'd0, y}) - longint'({32'd0, e.y});
          ok = e.exact ? (y === e.y) : (!$isunknown(y) && d >= -1 && d <= 1);
          n_cmp++;
          if (!ok) begin
            n_bad++;
            $display("FAIL quotient %h/%h: y=%h, required %h%s", e.a, e.b, y, e.y, e.exact ? "" : " +-1ulp");
          end
        end
      end
      if (final_chk) begin
        n_cmp++;
        if (sb.size() != 0) begin
          n_bad++;
          $display("FAIL drain: %0d results never appeared, required 0", sb.size());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [31:0] da[8] = '{32'h3F800000, 32'h40C00000, 32'h3F800000, 32'h80000000,
                           32'h00000000, 32'h7F000000, 32'h00800000, 32'h3F800000};
    logic [31:0] db[8] = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40000000,
                           32'hC0000000, 32'h00800000, 32'h7F000000, 32'h3FFFFFFF};
    logic [31:0] dy[8] = '{32'h3F800000, 32'hC0400000, 32'h3EAAAAAB, 32'h80000000,
                           32'h80000000, 32'h7F800000, 32'h00000000, 32'h3F000001};
    logic [31:0] a, b;
    logic [7:0]  e2;

    repeat (3) @(posedge clk);
    #1;
    chk_rst = 1'b1;
    @(posedge clk);
    #1;
    chk_rst = 1'b0;
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) push_op(da[i], db[i], dy[i], 1'b1);
    idle(4);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a = {1'($urandom), 8'(120 + $urandom_range(0, 14)), pick_frac()};
        b = {1'($urandom), 8'(120 + $urandom_range(0, 14)), pick_frac()};
        push_op(a, b, ref_div(a, b), 1'b1);
      end

    for (int e1 = 0; e1 <= 254; e1++)
      for (int j = 0; j < 40; j++) begin
        e2 = (j == 0) ? 8'd1 : (j == 1) ? 8'd254 : 8'($urandom_range(1, 254));
        a = {1'($urandom), 8'(e1), pick_frac()};
        b = {1'($urandom), e2, pick_frac()};
        push_op(a, b, ref_div(a, b), 1'b0);
      end
    idle(4);
    wait_drain();

    push_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
    idle(5);
    push_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b1);
    push_op(32'h40C00000, 32'hC0000000, 32'hC0400000, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk_rst = 1'b1;
    @(posedge clk);
    #1;
    chk_rst = 1'b0;
    rst = 1'b0;
    idle(8);

    push_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1);
    idle(5);
    wait_drain();

    final_chk = 1'b1;
    @(negedge clk);
    #1;
    final_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
